dff_stimulus_checker: RTL and testbench
=======================================

# dff_stimulus_checker

Synthesizable self-checking driver for a single-bit D flip-flop DUT (`d`, `reset`, `q`, `qb`). It produces the DUT-side stimulus and checks the DUT's response.
- Stimulus sequence: reset, release, re-reset, release, then a burst of data writes, each separated by a pseudo-random delay.
- Checking: DUT outputs are compared against an internal reference flop model.
- It sits next to the flop under test in on-chip self-test and in simulation regressions, replacing behavioural `#delay` stimulus.

## Interface
Parameters:
- `DELAY_W`, 6: width of random delay field; delay range 1..2^DELAY_W-1.
- `NUM_DATA`, 5: number of data writes in DRIVE phase.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  pulse; begins a run from IDLE or DONE.
- `dut_reset`  out  1  registered; active-high synchronous reset to DUT.
- `dut_d`  out  1  registered; DUT data input.
- `dut_q`  in  1  DUT output.
- `dut_qb`  in  1  DUT inverted output.
- `busy`  out  1  high from first cycle after accepted `start` until DONE.
- `done`  out  1  high in DONE.
- `err`  out  1  sticky mismatch flag, cleared on accepted `start`.
- `err_count`  out  8  mismatch cycles, saturates at 255, cleared on accepted `start`.

## Operation
- **States:** IDLE, WAIT0, RST1, REL1, RST2, REL2, DRIVE, DONE.
- **Transitions:** IDLE/DONE --start--> WAIT0 -> RST1 -> REL1 -> RST2 -> REL2 -> DRIVE -> DONE.
  - `start` is ignored in every other state.
- **Outputs per state (`dut_reset`/`dut_d`):**
  - IDLE 1/0; WAIT0 1/0; RST1 1/0; REL1 0/1; RST2 1/1; REL2 0/1.
  - DRIVE: 0, with `dut_d` updated as below.
  - DONE: 1/`dut_d` held.
- **Timed states (WAIT0..REL2, and each DRIVE iteration):**
  - On entry, `cnt <= (lfsr[DELAY_W-1:0]==0) ? 1 : lfsr[DELAY_W-1:0]`, and the LFSR advances one step.
  - The state lasts exactly `cnt` cycles; it exits when `cnt==1`.
- **DRIVE:** index `i` runs 0..NUM_DATA-1.
  - At the end of each iteration's delay, `dut_d <= i[0]`.
  - After the last write, go to DONE. A new delay is loaded per iteration.
- **LFSR:** 16-bit Galois, right-shift; when the shifted-out bit is 1, XOR with 16'hB400. Advances only on delay load.
- **Reference model:** `exp_q <= dut_reset ? 0 : dut_d` every cycle. `chk_en <= busy`.
- **Check, every cycle with `chk_en=1`:**
  - Mismatch if `dut_q != exp_q` or `dut_qb != ~dut_q`.
  - On mismatch: `err <= 1`; `err_count` increments, saturating at 255.
  - One increment per cycle even if both checks fail.
- **Reset (`reset=0`), asynchronous, any state including mid-run:**
  - State -> IDLE, `lfsr <= SEED`, `cnt <= 0`, `i <= 0`.
  - `dut_reset=1`, `dut_d=0`, `busy=0`, `done=0`, `err=0`, `err_count=0`, `exp_q=0`, `chk_en=0`.

## Timing
- Accepted `start` at edge k:
  - `busy=1` and `dut_reset=1` (WAIT0) after edge k.
  - `err` and `err_count` cleared at edge k.
- Stimulus latency: DUT sees new `dut_*` values at edge k+1. The check compares `dut_q` at the edge after that.
- `busy` falls and `done` rises in the same cycle on entry to DONE.
- `chk_en` lags `busy` by one cycle, so the final DUT response is still checked.
- Total run length is the sum of 5 + NUM_DATA delays.
- `start` asserted in the same cycle DONE is entered is ignored; it is only honoured in DONE.

## Structure
- Shared package `dff_stim_pkg`:
  - state enum `stim_state_t`;
  - LFSR width 16 and tap constant 16'hB400;
  - per-state `dut_reset`/`dut_d` constants.
- One sub-module `stim_lfsr`: parameterized seed, `step` input, 16-bit state output. It is reused for other randomized self-test blocks.
- FSM, delay counter, reference model and checker stay in the top module.

## Test plan
- **DELAY_W=1, correct behavioural DFF:** pulse `start` -> `busy` high exactly 10 cycles.
  - `dut_reset` pattern 1,1,0,1,0,0,0,0,0,0.
  - `dut_d` final value 0 (i=4).
  - `done=1`, `err=0`, `err_count=0`.
- **Default parameters, SEED=16'hACE1:** per-state durations and `dut_d` write times match the bench LFSR model cycle-for-cycle; `err=0`.
- **DUT `q` stuck at 0:** `err` sets on the first cycle `exp_q=1` is compared. `err_count` equals the number of checked cycles with `exp_q=1`.
- **DUT `qb` tied to `q`:** mismatch on every checked cycle. With DELAY_W=6, `err_count` saturates at 255 and stops.
- **`reset` low mid-DRIVE:** all outputs take reset values in the same cycle, without waiting for `clk`. After release and `start`, the delay sequence repeats identically to the first run.
- **`start` pulsed during RST2:** ignored, run unaffected. `start` in DONE restarts and clears `err`/`err_count`.

Source files
------------

// File: rtl/dff_stim_pkg.sv
// Shared definitions for the D flip-flop stimulus/checker block.
//   - stim_state_t : run sequencer states
//   - LFSR_W/LFSR_TAPS : 16-bit Galois LFSR geometry
//   - OUT_* : per-state {dut_reset, dut_d} drive values
//   - lfsr_next / next_timed_state / state_outputs : helper functions
package dff_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT0 = 3'd1,
    ST_RST1  = 3'd2,
    ST_REL1  = 3'd3,
    ST_RST2  = 3'd4,
    ST_REL2  = 3'd5,
    ST_DRIVE = 3'd6,
    ST_DONE  = 3'd7
  } stim_state_t;

  localparam int unsigned       LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Fixed drive values, packed as {dut_reset, dut_d}.
  localparam logic [1:0] OUT_IDLE  = 2'b10;
  localparam logic [1:0] OUT_WAIT0 = 2'b10;
  localparam logic [1:0] OUT_RST1  = 2'b10;
  localparam logic [1:0] OUT_REL1  = 2'b01;
  localparam logic [1:0] OUT_RST2  = 2'b11;
  localparam logic [1:0] OUT_REL2  = 2'b01;
  // DRIVE and DONE only fix dut_reset; dut_d carries the data written.
  localparam logic       OUT_DRIVE_RESET = 1'b0;
  localparam logic       OUT_DONE_RESET  = 1'b1;

  // One right-shift step of the Galois LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = {1'b0, s[LFSR_W-1:1]};
    if (s[0]) begin
      n = n ^ LFSR_TAPS;
    end else begin
      n = n;
    end
    return n;
  endfunction

  // Successor of each fixed-pattern timed state.
  function automatic stim_state_t next_timed_state(input stim_state_t s);
    stim_state_t n;
    case (s)
      ST_WAIT0: n = ST_RST1;
      ST_RST1:  n = ST_REL1;
      ST_REL1:  n = ST_RST2;
      ST_RST2:  n = ST_REL2;
      ST_REL2:  n = ST_DRIVE;
      default:  n = ST_IDLE;
    endcase
    return n;
  endfunction

  // {dut_reset, dut_d} to present while in state s; held_d is the data
  // value DRIVE/DONE keep on dut_d.
  function automatic logic [1:0] state_outputs(input stim_state_t s, input logic held_d);
    logic [1:0] o;
    case (s)
      ST_IDLE:  o = OUT_IDLE;
      ST_WAIT0: o = OUT_WAIT0;
      ST_RST1:  o = OUT_RST1;
      ST_REL1:  o = OUT_REL1;
      ST_RST2:  o = OUT_RST2;
      ST_REL2:  o = OUT_REL2;
      ST_DRIVE: o = {OUT_DRIVE_RESET, held_d};
      ST_DONE:  o = {OUT_DONE_RESET, held_d};
      default:  o = OUT_IDLE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 16-bit Galois LFSR that advances one step per cycle with `step` high.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, loads SEED
//   step  - advance one step this cycle
//   state - current LFSR contents
module stim_lfsr
  import dff_stim_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Next LFSR value: advance only when asked.
  always_comb begin
    if (step) begin
      state_d = lfsr_next(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/dff_stimulus_checker.sv
// Self-checking driver for a single-bit D flip-flop with synchronous
// active-high reset. It steps the flop through reset, release, re-reset,
// release and NUM_DATA data writes, each phase lasting a pseudo-random
// number of cycles, and compares q/qb against an internal reference flop.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   start     - begin a run (honoured in IDLE or DONE only)
//   dut_reset - registered reset to the flop under test
//   dut_d     - registered data to the flop under test
//   dut_q     - flop output
//   dut_qb    - flop inverted output
//   busy      - run in progress
//   done      - run finished
//   err       - sticky mismatch flag, cleared on accepted start
//   err_count - saturating count of mismatching cycles
module dff_stimulus_checker
  import dff_stim_pkg::*;
#(
  parameter int unsigned       DELAY_W  = 6,
  parameter int unsigned       NUM_DATA = 5,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       dut_reset,
  output logic       dut_d,
  input  logic       dut_q,
  input  logic       dut_qb,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] err_count
);

  localparam int unsigned      IDX_W    = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DATA - 1);

  stim_state_t        state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic               dut_reset_q, dut_reset_d;
  logic               dut_d_q, dut_d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               exp_q_q, exp_q_d;
  logic               chk_en_q, chk_en_d;
  logic               err_q, err_d;
  logic [7:0]         err_count_q, err_count_d;

  logic [LFSR_W-1:0]  lfsr_s;
  logic [DELAY_W-1:0] delay_s;
  logic               load_s;
  logic               accept_s;
  logic               data_s;
  logic               mismatch_s;
  logic               unused_lfsr_s;

  stim_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (reset),
    .step  (load_s),
    .state (lfsr_s)
  );

  // Only the low DELAY_W bits set the delay; the rest just feed the sequence.
  assign unused_lfsr_s = ^lfsr_s;

  // Delay for a newly entered timed state; zero would mean "no cycles", so it becomes 1.
  always_comb begin
    if (lfsr_s[DELAY_W-1:0] == {DELAY_W{1'b0}}) begin
      delay_s = DELAY_W'(1);
    end else begin
      delay_s = lfsr_s[DELAY_W-1:0];
    end
  end

  // Sequencer: next state, delay counter, DRIVE index and written data.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    i_d      = i_q;
    data_s   = dut_d_q;
    load_s   = 1'b0;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_WAIT0;
          i_d      = {IDX_W{1'b0}};
          cnt_d    = delay_s;
          load_s   = 1'b1;
          accept_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT0, ST_RST1, ST_REL1, ST_RST2, ST_REL2: begin
        // cnt counts the remaining cycles including the current one.
        if (cnt_q <= DELAY_W'(1)) begin
          state_d = next_timed_state(state_q);
          cnt_d   = delay_s;
          load_s  = 1'b1;
        end else begin
          cnt_d = cnt_q - DELAY_W'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q <= DELAY_W'(1)) begin
          // The write lands as the iteration's delay expires.
          data_s = i_q[0];
          if (i_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            i_d    = i_q + IDX_W'(1);
            cnt_d  = delay_s;
            load_s = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DELAY_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered drive and status values follow the state being entered.
  always_comb begin
    {dut_reset_d, dut_d_d} = state_outputs(state_d, data_s);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d   = (state_d == ST_DONE);
    // Reference flop sees exactly what the DUT sees on the same edge.
    exp_q_d  = dut_reset_q ? 1'b0 : dut_d_q;
    // One cycle behind busy so the last DRIVE response is still checked.
    chk_en_d = busy_q;
  end

  // Response check with sticky flag and saturating counter.
  always_comb begin
    mismatch_s  = chk_en_q && ((dut_q != exp_q_q) || (dut_qb != ~dut_q));
    err_d       = err_q;
    err_count_d = err_count_q;
    if (accept_s) begin
      err_d       = 1'b0;
      err_count_d = 8'd0;
    end else if (mismatch_s) begin
      err_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      err_d       = err_q;
      err_count_d = err_count_q;
    end
  end

  // State, counters, drive outputs, reference model and checker flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {DELAY_W{1'b0}};
      i_q         <= {IDX_W{1'b0}};
      dut_reset_q <= 1'b1;
      dut_d_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      exp_q_q     <= 1'b0;
      chk_en_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_q         <= i_d;
      dut_reset_q <= dut_reset_d;
      dut_d_q     <= dut_d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      exp_q_q     <= exp_q_d;
      chk_en_q    <= chk_en_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign dut_reset = dut_reset_q;
  assign dut_d     = dut_d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_dff_stimulus_checker.sv
// Bench for dff_stimulus_checker: instance A (DELAY_W=1) against a fixed
// vector table, instance B (default parameters) against a trace model
// built from the run rules and an arithmetic LFSR.
module tb_dff_stimulus_checker;

  localparam int          DW_B   = 6;
  localparam int          ND_B   = 5;
  localparam int          NSEG   = ND_B + 5;
  localparam logic [15:0] SEED_B = 16'hACE1;

  logic clk;
  logic rst_a_n, start_a, dut_reset_a, dut_d_a, dut_q_a, dut_qb_a;
  logic busy_a, done_a, err_a;
  logic [7:0] err_count_a;
  logic rst_b_n, start_b, dut_reset_b, dut_d_b, dut_q_b, dut_qb_b;
  logic busy_b, done_b, err_b;
  logic [7:0] err_count_b;

  logic qa_r = 1'b0;
  logic qb_r = 1'b0;
  int   mode_b;   // 0 good flop, 1 q stuck at 0, 2 qb tied to q

  int n_cmp = 0;
  int n_bad = 0;

  // Model state for instance B
  logic [15:0] m_lfsr;
  int          seg_start [0:NSEG];
  int          last_total;

  typedef struct packed {
    logic rst;
    logic d;
    logic busy;
    logic done;
  } vec_t;
  vec_t tbl [0:10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dff_stimulus_checker #(.DELAY_W(1), .NUM_DATA(5), .SEED(16'hACE1)) u_dut_a (
    .clk(clk), .reset(rst_a_n), .start(start_a),
    .dut_reset(dut_reset_a), .dut_d(dut_d_a), .dut_q(dut_q_a), .dut_qb(dut_qb_a),
    .busy(busy_a), .done(done_a), .err(err_a), .err_count(err_count_a)
  );

  dff_stimulus_checker #(.DELAY_W(DW_B), .NUM_DATA(ND_B), .SEED(SEED_B)) u_dut_b (
    .clk(clk), .reset(rst_b_n), .start(start_b),
    .dut_reset(dut_reset_b), .dut_d(dut_d_b), .dut_q(dut_q_b), .dut_qb(dut_qb_b),
    .busy(busy_b), .done(done_b), .err(err_b), .err_count(err_count_b)
  );

  // Flops under test: plain synchronous-reset DFFs, B with selectable faults.
  always @(posedge clk) qa_r <= dut_reset_a ? 1'b0 : dut_d_a;
  always @(posedge clk) qb_r <= dut_reset_b ? 1'b0 : dut_d_b;
  assign dut_q_a  = qa_r;
  assign dut_qb_a = ~qa_r;
  assign dut_q_b  = (mode_b == 1) ? 1'b0 : qb_r;
  assign dut_qb_b = (mode_b == 2) ? dut_q_b : ~dut_q_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {dut_reset, dut_d} in cycle s of a run of `total` busy cycles.
  function automatic logic [1:0] exp_drive(input int s, input int total);
    int seg;
    if (s >= total) return {1'b1, 1'((ND_B - 1) % 2)};
    seg = 0;
    for (int j = 0; j < NSEG; j++)
      if (s >= seg_start[j] && s < seg_start[j+1]) seg = j;
    case (seg)
      0, 1:    return 2'b10;
      2:       return 2'b01;
      3:       return 2'b11;
      4:       return 2'b01;
      5:       return 2'b01;           // first iteration still shows REL2's data
      default: return {1'b0, 1'((seg - 6) % 2)};
    endcase
  endfunction

  task automatic run_a(input int stray);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int s = 0; s <= 10; s++) begin
      check($sformatf("A_cyc%0d", s),
            {19'd0, dut_reset_a, dut_d_a, busy_a, done_a, err_a, err_count_a},
            {19'd0, tbl[s], 1'b0, 8'd0});
      start_a = (s == stray) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  // stray: 0 none, 1 random busy cycle, 2 last busy cycle. abort: 1 = stop mid-DRIVE.
  task automatic run_b(input int mode, input int stray, input int abort);
    int total, stray_at, abort_at, len, mis, e_cnt;
    logic [1:0] dr, dt;
    logic e;
    mode_b = mode;
    seg_start[0] = 0;
    for (int j = 0; j < NSEG; j++) begin
      len = int'(m_lfsr) % (1 << DW_B);
      if (len == 0) len = 1;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      seg_start[j+1] = seg_start[j] + len;
    end
    total = seg_start[NSEG];
    last_total = total;
    stray_at = (stray == 1) ? int'($urandom_range(0, total - 1)) : ((stray == 2) ? total - 1 : -1);
    abort_at = (abort == 1) ? seg_start[5] + 1 : -1;
    mis = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int s = 0; s <= total + 1; s++) begin
      if (s >= 2 && s - 2 < total) begin
        dt = exp_drive(s - 2, total);
        e  = dt[1] ? 1'b0 : dt[0];
        if (mode == 2 || (mode == 1 && e)) mis++;
      end
      e_cnt = (mis > 255) ? 255 : mis;
      dr = exp_drive(s, total);
      check($sformatf("B_m%0d_cyc%0d", mode, s),
            {19'd0, dut_reset_b, dut_d_b, busy_b, done_b, err_b, err_count_b},
            {19'd0, dr, (s < total), (s >= total), (mis > 0), 8'(e_cnt)});
      if (s == abort_at) break;
      start_b = (s == stray_at) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start_b = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    mode_b  = 0;
    m_lfsr  = SEED_B;
    repeat (3) @(negedge clk);
    check("A_reset", {19'd0, dut_reset_a, dut_d_a, busy_a, done_a, err_a, err_count_a}, 32'h1000);
    check("B_reset", {19'd0, dut_reset_b, dut_d_b, busy_b, done_b, err_b, err_count_b}, 32'h1000);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    repeat (2) @(negedge clk);
    check("A_idle", {19'd0, dut_reset_a, dut_d_a, busy_a, done_a, err_a, err_count_a}, 32'h1000);

    // DELAY_W=1: every phase one cycle; second run has start pulsed in RST2.
    run_a(-1);
    run_a(3);

    // Default parameters: good flop, stuck q, tied qb, then restart clears.
    run_b(0, 1, 0);
    run_b(1, 2, 0);
    run_b(2, 0, 0);
    check("B_saturate", {24'd0, err_count_b}, (last_total > 255) ? 255 : last_total);
    run_b(0, 0, 0);
    repeat (2) run_b(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);

    // Asynchronous reset in the middle of DRIVE, then an identical rerun.
    rst_b_n = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b1;
    m_lfsr  = SEED_B;
    @(negedge clk);
    run_b(1, 0, 1);
    check("B_pre_reset_busy", {31'd0, busy_b}, 32'd1);
    #2 rst_b_n = 1'b0;
    #1 check("B_async_reset",
             {19'd0, dut_reset_b, dut_d_b, busy_b, done_b, err_b, err_count_b}, 32'h1000);
    m_lfsr = SEED_B;
    @(negedge clk);
    rst_b_n = 1'b1;
    @(negedge clk);
    run_b(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
